// File: rtl/processor_defines.sv
// Shared processor definitions: fetch FSM state encoding and the reset fetch address.
package processor_defines;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads to imem and hands one
// instruction at a time to decode, discarding fetches made stale by redirects.
module fetch_unit
  import processor_defines::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        pc_update_control,
  input  logic [31:0] pc_update_val,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] prev_pc,
  output logic        fetch_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         req_q, req_d;
  logic [31:0]  inst_q, inst_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  prev_pc_q, prev_pc_d;
  logic         fault_q, fault_d;

  logic xfer, redir, misalign;

  assign xfer     = req_q & imem_ready;
  assign misalign = pc_update_control & (pc_update_val[1:0] != 2'b00);
  assign redir    = pc_update_control & ~misalign;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tgt_d      = tgt_q;
    req_d      = req_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    prev_pc_d  = prev_pc_q;
    fault_d    = fault_q;

    if (state_q == FAULT) begin
      req_d   = 1'b0;
      valid_d = 1'b0;
    end else if (misalign) begin
      state_d = FAULT;
      fault_d = 1'b1;
      valid_d = 1'b0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          req_d = 1'b1;
          if (xfer) begin
            if (redir) begin
              fetch_pc_d = pc_update_val;
            end else begin
              inst_d     = imem_rdata;
              pc_d       = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + INST_BYTES;
              valid_d    = 1'b1;
              req_d      = 1'b0;
              state_d    = HOLD;
            end
          end else if (redir) begin
            // With nothing outstanding (first cycle after reset) the target
            // can be taken directly; otherwise the pending read must drain.
            if (req_q) begin
              tgt_d   = pc_update_val;
              state_d = DROP;
            end else begin
              fetch_pc_d = pc_update_val;
            end
          end
        end
        HOLD: begin
          if (redir) begin
            fetch_pc_d = pc_update_val;
            valid_d    = 1'b0;
            req_d      = 1'b1;
            state_d    = FETCH;
          end else if (!stall) begin
            prev_pc_d = pc_q;
            valid_d   = 1'b0;
            req_d     = 1'b1;
            state_d   = FETCH;
          end
        end
        DROP: begin
          req_d = 1'b1;
          if (xfer) begin
            fetch_pc_d = redir ? pc_update_val : tgt_q;
            state_d    = FETCH;
          end else if (redir) begin
            tgt_d = pc_update_val;
          end
        end
        default: state_d = FAULT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      tgt_q      <= RESET_PC;
      req_q      <= 1'b0;
      inst_q     <= 32'h0;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      prev_pc_q  <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tgt_q      <= tgt_d;
      req_q      <= req_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      prev_pc_q  <= prev_pc_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc_q;
  assign inst        = inst_q;
  assign inst_valid  = valid_q;
  assign pc          = pc_q;
  assign prev_pc     = prev_pc_q;
  assign fetch_fault = fault_q;

endmodule
